// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 8;
  localparam int CNT_W     = $clog2(SUB_WIDTH);

  // Bit-counter width for an arbitrary operand width; never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fullsubtractor_struct.sv
// Gate-level full-subtractor cell: diff = x ^ y ^ bin,
// bout = (~x & y) | (~(x ^ y) & bin).
module fullsubtractor_struct (
  input  logic x,
  input  logic y,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  wire x_xor_y;
  wire x_n;
  wire xy_n;
  wire brw_gen;
  wire brw_prop;

  xor g_xor0 (x_xor_y, x, y);
  xor g_xor1 (diff, x_xor_y, borrow_in);
  not g_not0 (x_n, x);
  and g_and0 (brw_gen, x_n, y);
  not g_not1 (xy_n, x_xor_y);
  and g_and1 (brw_prop, xy_n, borrow_in);
  or  g_or0  (borrow_out, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor cell
// plus a registered borrow, with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            bor;
  logic [CW-1:0]   cnt;
  logic            cell_d;
  logic            cell_bout;
  logic            accept;
  logic            last_bit;

  fullsubtractor_struct u_cell (
    .x          (a_sh[0]),
    .y          (b_sh[0]),
    .borrow_in  (bor),
    .diff       (cell_d),
    .borrow_out (cell_bout)
  );

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (cnt == LAST_BIT);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (last_bit) state_nxt = ST_DONE;
        else          state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt = ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Serial datapath: operand shifters, borrow flop, counter and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      bor        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_sh       <= a;
      b_sh       <= b;
      bor        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (state == ST_RUN) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      diff <= {cell_d, diff[WIDTH-1:1]};
      bor  <= cell_bout;
      cnt  <= cnt + CW'(1);
      // Overflow is the borrow into the MSB disagreeing with the borrow out.
      if (last_bit) begin
        borrow_out <= cell_bout;
        overflow   <= bor ^ cell_bout;
      end else begin
        borrow_out <= borrow_out;
        overflow   <= overflow;
      end
    end else begin
      a_sh       <= a_sh;
      b_sh       <= b_sh;
      bor        <= bor;
      cnt        <= cnt;
      diff       <= diff;
      borrow_out <= borrow_out;
      overflow   <= overflow;
    end
  end

endmodule
